seq_accumulator: RTL and testbench
==================================

SEQ_ACCUMULATOR -- requirements
Module: seq_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default MSB from project_pkg; operand width in bits.
REQ-002 SHALL have parameter COUNT, default 4; operands summed per result, legal range 1..256.
REQ-003 SHALL have derived localparam ACCW = WIDTH + $clog2(COUNT), or WIDTH when COUNT==1; result width.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port clear  input  1  synchronous abort of the current accumulation.
REQ-007 Port in_valid  input  1  in_data is valid this cycle.
REQ-008 Port in_ready  output  1  block accepts an operand this cycle.
REQ-009 Port in_data  input  WIDTH  unsigned operand.
REQ-010 Port out_valid  output  1  out_sum and out_carry are valid.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port out_sum  output  ACCW  accumulated unsigned sum.
REQ-013 Port out_carry  output  1  sum exceeded 2^WIDTH-1.
REQ-014 Port busy  output  1  accumulation in progress (state ACC).

Function
REQ-015 SHALL implement FSM states IDLE, ACC, DONE.
REQ-016 Operand transfer SHALL occur only on a cycle with in_valid && in_ready; result transfer only on out_valid && out_ready.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-018 out_valid SHALL be 1 only in DONE; out_sum and out_carry SHALL be held stable while out_valid && !out_ready.
REQ-019 IDLE with transfer: acc = in_data, cnt = 1; next state ACC, or DONE when COUNT==1.
REQ-020 ACC with transfer: acc = acc + in_data at full ACCW width, cnt = cnt + 1; next state DONE when the transfer is operand COUNT.
REQ-021 ACC without transfer (in_valid gap): acc, cnt and state SHALL hold.
REQ-022 DONE with result transfer: next state IDLE, cnt = 0; acc SHALL not be cleared.
REQ-023 Latency: out_valid SHALL assert on the cycle after the transfer of operand COUNT.
REQ-024 Throughput: one operand per cycle; minimum COUNT+1 cycles per result.
REQ-025 out_carry SHALL equal |out_sum[ACCW-1:WIDTH]; it SHALL be 0 when ACCW==WIDTH.
REQ-026 ACCW SHALL be sized so the sum never wraps.
REQ-027 clear SHALL force state IDLE, acc = 0 and cnt = 0 on the next edge, in every state.
REQ-028 clear SHALL have priority over a simultaneous operand transfer, which is discarded.
REQ-029 clear SHALL have priority over a simultaneous result transfer, which is dropped.
REQ-030 busy SHALL be 1 exactly when state is ACC.

Reset
REQ-031 While rst_n==0, outputs SHALL be: state IDLE, acc 0, cnt 0, out_valid 0, in_ready 1, busy 0, out_sum 0, out_carry 0.
REQ-032 Reset asserted mid-accumulation or in DONE SHALL discard all partial state immediately, without waiting for clk.

Configuration
REQ-033 With ACC_SAT_EN defined, out_sum SHALL saturate at 2^WIDTH-1 when the internal sum exceeds it.
REQ-034 With ACC_SAT_EN defined, out_carry SHALL be 1 iff saturation occurred; the upper ACCW-WIDTH bits of out_sum SHALL read 0.
REQ-035 Without ACC_SAT_EN, out_sum SHALL carry the full ACCW-bit sum, with out_carry per REQ-025.

Structure
REQ-036 project_pkg SHALL hold the MSB default and the typedef acc_state_t (IDLE, ACC, DONE).
REQ-037 A matching interface intf_seqAcc SHALL provide modports dut and tb.
REQ-038 A combinational sub-module acc_adder (ACCW-bit a + zero-extended WIDTH-bit b) SHALL perform the addition; the FSM and registers SHALL stay in seq_accumulator.

Verification
REQ-039 WIDTH=8, COUNT=4, in_data 10,20,30,40 back-to-back -> out_valid one cycle after 40; out_sum=100, out_carry=0.
REQ-040 WIDTH=8, COUNT=4, four operands of 255 -> out_sum=1020 (0x3FC), out_carry=1; with ACC_SAT_EN -> out_sum=255, out_carry=1.
REQ-041 out_ready held 0 for 5 cycles in DONE -> out_sum stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-042 clear asserted after 2 operands, then operands 1,1,1,1 -> out_sum=4.
REQ-043 clear coincident with operand 4 -> no out_valid; state returns to IDLE.
REQ-044 rst_n pulsed low in ACC -> immediate IDLE with outputs per REQ-031; in_valid gaps of 3 cycles between operands -> same result as the back-to-back case.
REQ-045 COUNT=1, in_data 7 -> out_valid next cycle with out_sum=7.

Source files
------------

// File: rtl/project_pkg.sv
// project_pkg: shared defaults and FSM state type for the sequence accumulator.
package project_pkg;

    // Default operand width in bits.
    localparam int MSB = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    // Result width: enough headroom that summing `count` operands never wraps.
    function automatic int acc_width(input int width, input int count);
        return (count <= 1) ? width : width + $clog2(count);
    endfunction

endpackage

// File: rtl/intf_seqAcc.sv
// intf_seqAcc: bundle of the seq_accumulator handshake signals.
interface intf_seqAcc #(
    parameter int WIDTH = project_pkg::MSB,
    parameter int COUNT = 4
) (
    input logic clk,
    input logic rst_n
);
    import project_pkg::*;

    localparam int ACCW = acc_width(WIDTH, COUNT);

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACCW-1:0]  out_sum;
    logic             out_carry;
    logic             busy;

    modport dut (
        input  clk, rst_n, clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_carry, busy
    );

    modport tb (
        input  clk, rst_n, in_ready, out_valid, out_sum, out_carry, busy,
        output clear, in_valid, in_data, out_ready
    );

endinterface

// File: rtl/acc_adder.sv
// acc_adder: combinational ACCW-bit accumulator plus zero-extended WIDTH-bit operand.
module acc_adder #(
    parameter int WIDTH = project_pkg::MSB,
    parameter int ACCW  = WIDTH
) (
    input  logic [ACCW-1:0]  a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [ACCW-1:0]  sum_o
);

    assign sum_o = a_i + ACCW'(b_i);

endmodule

// File: rtl/seq_accumulator.sv
// seq_accumulator: sums COUNT unsigned operands per result over a valid/ready
// handshake (IDLE -> ACC -> DONE). Define ACC_SAT_EN to saturate out_sum at
// 2^WIDTH-1 instead of presenting the full-width sum.
module seq_accumulator
    import project_pkg::*;
#(
    parameter int WIDTH = MSB,
    parameter int COUNT = 4,
    localparam int ACCW = acc_width(WIDTH, COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACCW-1:0]  out_sum,
    output logic             out_carry,
    output logic             busy
);

    // Counter must be able to hold COUNT itself.
    localparam int              CNTW     = $clog2(COUNT + 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(COUNT - 1);

    acc_state_t      state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            in_fire;
    logic            out_fire;
    logic [ACCW-1:0] add_a;
    logic [ACCW-1:0] add_sum;
    logic            over_max;

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACC);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // The first operand of a run starts from zero rather than the stale result.
    assign add_a = (state_q == IDLE) ? '0 : acc_q;

    acc_adder #(
        .WIDTH (WIDTH),
        .ACCW  (ACCW)
    ) u_adder (
        .a_i   (add_a),
        .b_i   (in_data),
        .sum_o (add_sum)
    );

    // Next-state logic; clear overrides any simultaneous operand or result transfer.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        acc_d   = add_sum;
                        cnt_d   = CNT_ONE;
                        state_d = (COUNT == 1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (in_fire) begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == LAST_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    // The result stays in acc so out_sum remains readable after hand-off.
                    if (out_fire) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers; reset discards any partial accumulation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any bit above WIDTH set means the sum exceeded 2^WIDTH-1.
    assign over_max  = |(acc_q >> WIDTH);
    assign out_carry = over_max;

`ifdef ACC_SAT_EN
    localparam logic [ACCW-1:0] SAT_MAX = ACCW'({WIDTH{1'b1}});

    assign out_sum = over_max ? SAT_MAX : acc_q;
`else
    assign out_sum = acc_q;
`endif

endmodule

// File: tb/tb_seq_accumulator.sv
// tb_seq_accumulator: randomized and directed checks of seq_accumulator
// (COUNT=4 and COUNT=1 instances) against a sum-of-operands reference model.
module tb_seq_accumulator;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int ACCW = W + $clog2(N);
    localparam int MAXV = (1 << W) - 1;

    logic            clk;
    logic            rst_n;
    logic            clear, in_valid, in_ready, out_valid, out_ready, out_carry, busy;
    logic [W-1:0]    in_data;
    logic [ACCW-1:0] out_sum;

    logic            clear1, in_valid1, in_ready1, out_valid1, out_ready1, out_carry1, busy1;
    logic [W-1:0]    in_data1;
    logic [W-1:0]    out_sum1;

    int checks;
    int errors;

    seq_accumulator #(.WIDTH(W), .COUNT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    seq_accumulator #(.WIDTH(W), .COUNT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (out_sum1),
        .out_carry (out_carry1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: the plain arithmetic sum of the batch, optionally clipped.
    function automatic int model_total(input int q[$]);
        int total = 0;
        foreach (q[i]) total += q[i];
        return total;
    endfunction

    function automatic int model_sum(input int q[$]);
        int total = model_total(q);
`ifdef ACC_SAT_EN
        if (total > MAXV) return MAXV;
`endif
        return total;
    endfunction

    function automatic int model_carry(input int q[$]);
        return (model_total(q) > MAXV) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present each operand after `gap` idle cycles; out_valid must stay low until the last one lands.
    task automatic feed(input int q[$], input int gap);
        foreach (q[i]) begin
            in_valid = 1'b0;
            repeat (gap) tick();
            in_valid = 1'b1;
            in_data  = q[i][W-1:0];
            check("no_early_valid", {31'd0, out_valid}, 32'd0);
            tick();
            if (i < q.size() - 1) check("busy_in_acc", {31'd0, busy}, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag, input int q[$]);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_sum"}, 32'(out_sum), model_sum(q));
        check({tag, "_carry"}, {31'd0, out_carry}, model_carry(q));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_after_consume_valid", {31'd0, out_valid}, 32'd0);
        check("idle_after_consume_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic expect_cleared(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_sum"}, 32'(out_sum), 32'd0);
        check({tag, "_carry"}, {31'd0, out_carry}, 32'd0);
    endtask

    initial begin
        int q[$];
        int gap;
        int hold;

        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        clear1     = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;

        // Reset values while rst_n is held low.
        #3;
        expect_cleared("reset");
        check("reset1_valid", {31'd0, out_valid1}, 32'd0);
        check("reset1_in_ready", {31'd0, in_ready1}, 32'd1);
        check("reset1_sum", 32'(out_sum1), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back 10,20,30,40.
        q = {10, 20, 30, 40};
        feed(q, 0);
        expect_done("b2b", q);
        consume();

        // Four maximal operands exercise the carry / saturation path.
        q = {255, 255, 255, 255};
        feed(q, 0);
        expect_done("max", q);

        // Consumer stalls 5 cycles: result holds, new operands are ignored.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = W'($urandom_range(MAXV));
            tick();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_sum", 32'(out_sum), model_sum(q));
        end
        in_valid = 1'b0;
        consume();

        // Clear after two operands, then a fresh batch of ones.
        q = {$urandom_range(MAXV), $urandom_range(MAXV)};
        feed(q, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_cleared("clear_mid");
        q = {1, 1, 1, 1};
        feed(q, 0);
        expect_done("after_clear", q);
        consume();

        // Clear coincident with operand 4 discards it.
        q = {5, 6, 7};
        feed(q, 0);
        in_valid = 1'b1;
        in_data  = 8'd8;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        expect_cleared("clear_op4");
        tick();
        tick();
        check("clear_op4_no_valid_later", {31'd0, out_valid}, 32'd0);

        // Clear coincident with result hand-off drops the result.
        q = {3, 4, 5, 6};
        feed(q, 0);
        expect_done("pre_clear_done", q);
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        expect_cleared("clear_done");

        // Async reset in ACC takes effect without a clock edge.
        q = {100, 100};
        feed(q, 0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_cleared("async_rst");
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        // Three-cycle gaps give the same result as back-to-back.
        q = {10, 20, 30, 40};
        feed(q, 3);
        expect_done("gap3", q);
        consume();

        // Randomized batches with random gaps and stall lengths.
        for (int b = 0; b < 20; b++) begin
            q.delete();
            for (int i = 0; i < N; i++) begin
                q.push_back((b % 3 == 0) ? $urandom_range(MAXV, 200) : $urandom_range(MAXV));
            end
            gap = $urandom_range(2);
            feed(q, gap);
            expect_done("rand", q);
            hold = $urandom_range(3);
            repeat (hold) begin
                tick();
                check("rand_hold_sum", 32'(out_sum), model_sum(q));
            end
            consume();
        end

        // COUNT=1: the result appears on the cycle after the single operand.
        in_valid1 = 1'b1;
        in_data1  = 8'd7;
        check("c1_no_early_valid", {31'd0, out_valid1}, 32'd0);
        tick();
        in_valid1 = 1'b0;
        check("c1_valid", {31'd0, out_valid1}, 32'd1);
        check("c1_sum", 32'(out_sum1), 32'd7);
        check("c1_carry", {31'd0, out_carry1}, 32'd0);
        check("c1_busy", {31'd0, busy1}, 32'd0);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("c1_idle", {31'd0, out_valid1}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            q = {$urandom_range(MAXV)};
            in_valid1 = 1'b1;
            in_data1  = W'(q[0]);
            tick();
            in_valid1 = 1'b0;
            check("c1_rand_sum", 32'(out_sum1), model_sum(q));
            check("c1_rand_carry", {31'd0, out_carry1}, model_carry(q));
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
